memory_port_responder: RTL and testbench

MEMORY_PORT_RESPONDER -- requirements
Module: memory_port_responder

---
 rtl/memory_port_responder.sv | 130 +++++++++++++
 tb/tb_memory_port_responder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_port_responder.sv
// memory_port_responder: bridges four-phase read/write core handshakes onto a single-outstanding Avalon-MM master.
// A tie between read and write requests goes to the port that was not served last.
module memory_port_responder (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [24:0] read_address,
    input  logic        read_n,
    output logic [31:0] read_data,
    output logic        data_ready_n,
    input  logic [24:0] write_address,
    input  logic [31:0] write_data,
    input  logic        write_n,
    output logic        data_written_n,
    output logic [24:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid
);
    typedef enum logic [2:0] {IDLE, RD_CMD, RD_WAIT, RD_DONE, WR_CMD, WR_DONE} state_t;

    state_t      state, state_nx;
    logic        last_served, last_served_nx;
    logic        abandon, abandon_nx;
    logic        read_nx, write_nx, ready_n_nx, written_n_nx;
    logic [24:0] address_nx;
    logic [31:0] writedata_nx, read_data_nx;
    logic        pick_read, pick_write, quit;

    assign avm_byteenable = 4'hF;
    assign pick_write = !write_n && (read_n || !last_served);
    assign pick_read  = !read_n && (write_n || last_served);
    // quit: the core has dropped (or already dropped) the request being served
    assign quit = abandon | ((state == WR_CMD || state == WR_DONE) ? write_n : read_n);

    always_comb begin
        state_nx       = state;
        last_served_nx = last_served;
        abandon_nx     = abandon;
        read_nx        = avm_read;
        write_nx       = avm_write;
        ready_n_nx     = data_ready_n;
        written_n_nx   = data_written_n;
        address_nx     = avm_address;
        writedata_nx   = avm_writedata;
        read_data_nx   = read_data;
        case (state)
            IDLE: begin
                abandon_nx = 1'b0;
                if (pick_write) begin
                    state_nx       = WR_CMD;
                    write_nx       = 1'b1;
                    address_nx     = write_address & ~25'h3;
                    writedata_nx   = write_data;
                    last_served_nx = 1'b1;
                end else if (pick_read) begin
                    state_nx       = RD_CMD;
                    read_nx        = 1'b1;
                    address_nx     = read_address & ~25'h3;
                    last_served_nx = 1'b0;
                end
            end
            RD_CMD: begin
                abandon_nx = quit;
                if (!avm_waitrequest) begin
                    read_nx  = 1'b0;
                    state_nx = RD_WAIT;
                end
            end
            RD_WAIT: begin
                abandon_nx = quit;
                if (avm_readdatavalid) begin
                    state_nx     = RD_DONE;
                    ready_n_nx   = quit;
                    read_data_nx = quit ? read_data : avm_readdata;
                end
            end
            RD_DONE: begin
                if (quit) begin
                    ready_n_nx = 1'b1;
                    state_nx   = IDLE;
                end
            end
            WR_CMD: begin
                abandon_nx = quit;
                if (!avm_waitrequest) begin
                    write_nx     = 1'b0;
                    written_n_nx = quit;
                    state_nx     = WR_DONE;
                end
            end
            WR_DONE: begin
                if (quit) begin
                    written_n_nx = 1'b1;
                    state_nx     = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state          <= IDLE;
            last_served    <= 1'b0;
            abandon        <= 1'b0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            data_ready_n   <= 1'b1;
            data_written_n <= 1'b1;
            avm_address    <= '0;
            avm_writedata  <= '0;
            read_data      <= '0;
        end else begin
            state          <= state_nx;
            last_served    <= last_served_nx;
            abandon        <= abandon_nx;
            avm_read       <= read_nx;
            avm_write      <= write_nx;
            data_ready_n   <= ready_n_nx;
            data_written_n <= written_n_nx;
            avm_address    <= address_nx;
            avm_writedata  <= writedata_nx;
            read_data      <= read_data_nx;
        end
    end
endmodule

// File: tb/tb_memory_port_responder.sv
// tb_memory_port_responder: table-driven vectors plus directed multi-cycle sequences for memory_port_responder.
module tb_memory_port_responder;
    logic        clock = 1'b0;
    logic        reset_n, read_n, write_n, avm_waitrequest, avm_readdatavalid;
    logic [24:0] read_address, write_address, avm_address;
    logic [31:0] write_data, avm_readdata, read_data, avm_writedata;
    logic        data_ready_n, data_written_n, avm_read, avm_write;
    logic [3:0]  avm_byteenable;
    int          errors = 0, checks = 0;

    always #5 clock = ~clock;

    memory_port_responder dut (
        .clock(clock), .reset_n(reset_n),
        .read_address(read_address), .read_n(read_n), .read_data(read_data), .data_ready_n(data_ready_n),
        .write_address(write_address), .write_data(write_data), .write_n(write_n), .data_written_n(data_written_n),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid)
    );

    typedef struct {
        logic        rst_n, rd_n, wr_n;
        logic [24:0] ra, wa;
        logic [31:0] wd;
        logic        wq, rv;
        logic [31:0] rdat;
        logic [92:0] exp;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t v(input logic rn, rd, wr, input logic [24:0] ra, input logic [31:0] wd,
                               input logic wq, rv, input logic [31:0] rdat,
                               input logic ar, aw, drn, dwn, input logic [24:0] ad,
                               input logic [31:0] wdo, rdo);
        v.rst_n = rn; v.rd_n = rd; v.wr_n = wr; v.ra = ra; v.wa = 25'h40; v.wd = wd;
        v.wq = wq; v.rv = rv; v.rdat = rdat;
        v.exp = {ar, aw, drn, dwn, ad, wdo, rdo};
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset_n = 1'b0; read_n = 1'b1; write_n = 1'b1;
        avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
        tick;
        reset_n = 1'b1;
    endtask

    logic        mon_en = 1'b0;
    logic [24:0] acc_addr[$];
    logic [31:0] acc_data[$];

    always @(posedge clock)
        if (mon_en && avm_write && !avm_waitrequest) begin
            acc_addr.push_back(avm_address);
            acc_data.push_back(avm_writedata);
        end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        reset_n = 1'b0; read_n = 1'b1; write_n = 1'b1;
        read_address = '0; write_address = '0; write_data = '0;
        avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;

        // basic read, stalled write with input changes ignored, top-address read
        vt.push_back(v(0,1,1,25'h103,32'h12345678,0,0,32'h0,        0,0,1,1,25'h0,      32'h0,       32'h0));
        vt.push_back(v(1,0,1,25'h103,32'h12345678,0,0,32'h0,        1,0,1,1,25'h100,    32'h0,       32'h0));
        vt.push_back(v(1,0,1,25'h103,32'h12345678,0,0,32'h0,        0,0,1,1,25'h100,    32'h0,       32'h0));
        vt.push_back(v(1,0,1,25'h103,32'h12345678,0,1,32'hDEADBEEF, 0,0,0,1,25'h100,    32'h0,       32'hDEADBEEF));
        vt.push_back(v(1,0,1,25'h103,32'h12345678,0,0,32'h0,        0,0,0,1,25'h100,    32'h0,       32'hDEADBEEF));
        vt.push_back(v(1,1,1,25'h103,32'h12345678,0,0,32'h0,        0,0,1,1,25'h100,    32'h0,       32'hDEADBEEF));
        vt.push_back(v(1,1,0,25'h103,32'h12345678,1,0,32'h0,        0,1,1,1,25'h040,    32'h12345678,32'hDEADBEEF));
        vt.push_back(v(1,1,0,25'h103,32'h0,       1,1,32'h11111111, 0,1,1,1,25'h040,    32'h12345678,32'hDEADBEEF));
        vt.push_back(v(1,1,0,25'h103,32'h0,       1,0,32'h0,        0,1,1,1,25'h040,    32'h12345678,32'hDEADBEEF));
        vt.push_back(v(1,1,0,25'h103,32'h0,       1,0,32'h0,        0,1,1,1,25'h040,    32'h12345678,32'hDEADBEEF));
        vt.push_back(v(1,1,0,25'h103,32'h0,       0,0,32'h0,        0,0,1,0,25'h040,    32'h12345678,32'hDEADBEEF));
        vt.push_back(v(1,1,0,25'h103,32'h0,       0,0,32'h0,        0,0,1,0,25'h040,    32'h12345678,32'hDEADBEEF));
        vt.push_back(v(1,1,1,25'h103,32'h0,       0,1,32'hFFFFFFFF, 0,0,1,1,25'h040,    32'h12345678,32'hDEADBEEF));
        vt.push_back(v(1,0,1,25'h1FFFFFF,32'h0,   0,0,32'h0,        1,0,1,1,25'h1FFFFFC,32'h12345678,32'hDEADBEEF));
        vt.push_back(v(1,0,1,25'h1FFFFFF,32'h0,   0,0,32'h0,        0,0,1,1,25'h1FFFFFC,32'h12345678,32'hDEADBEEF));
        vt.push_back(v(1,0,1,25'h1FFFFFF,32'h0,   0,1,32'h0,        0,0,0,1,25'h1FFFFFC,32'h12345678,32'h0));
        vt.push_back(v(1,1,1,25'h1FFFFFF,32'h0,   0,0,32'h0,        0,0,1,1,25'h1FFFFFC,32'h12345678,32'h0));

        foreach (vt[i]) begin
            reset_n = vt[i].rst_n; read_n = vt[i].rd_n; write_n = vt[i].wr_n;
            read_address = vt[i].ra; write_address = vt[i].wa; write_data = vt[i].wd;
            avm_waitrequest = vt[i].wq; avm_readdatavalid = vt[i].rv; avm_readdata = vt[i].rdat;
            tick;
            check($sformatf("vec%0d", i),
                  {avm_read, avm_write, data_ready_n, data_written_n, avm_address, avm_writedata, read_data},
                  vt[i].exp);
        end
        check("byteenable", avm_byteenable, 4'hF);

        // simultaneous requests alternate, write first after reset
        do_reset;
        read_address = 25'h204; write_address = 25'h308; write_data = 32'hCAFEF00D;
        read_n = 1'b0; write_n = 1'b0;
        tick; check("tie1_write", {avm_read, avm_write, avm_address}, {1'b0, 1'b1, 25'h308});
        tick; check("tie1_written", data_written_n, 1'b0);
        write_n = 1'b1;
        tick; check("tie1_release", {data_written_n, avm_read}, {1'b1, 1'b0});
        tick; check("tie2_read", {avm_read, avm_write, avm_address}, {1'b1, 1'b0, 25'h204});
        tick;
        avm_readdatavalid = 1'b1; avm_readdata = 32'h0BADF00D;
        tick; avm_readdatavalid = 1'b0;
        check("tie2_data", {data_ready_n, read_data}, {1'b0, 32'h0BADF00D});
        read_n = 1'b1;
        tick; check("tie2_release", data_ready_n, 1'b1);
        read_n = 1'b0; write_n = 1'b0;
        tick; check("tie3_write", {avm_read, avm_write}, {1'b0, 1'b1});

        // abandoned read: late data discarded, next read normal
        do_reset;
        read_address = 25'h0A8; read_n = 1'b0;
        tick; tick;
        read_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick; check($sformatf("abandon_wait%0d", i), {data_ready_n, avm_read}, {1'b1, 1'b0});
        end
        avm_readdatavalid = 1'b1; avm_readdata = 32'h55AA55AA;
        tick; avm_readdatavalid = 1'b0;
        check("abandon_rdv", data_ready_n, 1'b1);
        tick; check("abandon_idle", data_ready_n, 1'b1);
        read_address = 25'h0AC; read_n = 1'b0;
        tick; check("next_read_cmd", {avm_read, avm_address}, {1'b1, 25'h0AC});
        tick;
        avm_readdatavalid = 1'b1; avm_readdata = 32'h13579BDF;
        tick; avm_readdatavalid = 1'b0;
        check("next_read_data", {data_ready_n, read_data}, {1'b0, 32'h13579BDF});
        read_n = 1'b1;
        tick; check("next_read_release", data_ready_n, 1'b1);

        // abandoned write: completes on the bus, never signals done
        do_reset;
        write_address = 25'h10; write_data = 32'h0F0F0F0F; write_n = 1'b0; avm_waitrequest = 1'b1;
        tick;
        write_n = 1'b1;
        tick; check("abandon_wr_stall", {avm_write, data_written_n}, {1'b1, 1'b1});
        avm_waitrequest = 1'b0;
        tick; check("abandon_wr_accept", {avm_write, data_written_n}, {1'b0, 1'b1});
        tick; check("abandon_wr_idle", data_written_n, 1'b1);

        // reset during RD_WAIT, late readdatavalid ignored, immediate new request
        do_reset;
        read_address = 25'h123; read_n = 1'b0;
        tick; tick;
        reset_n = 1'b0;
        tick; check("rst_mid_read", {avm_read, data_ready_n, read_data, avm_address}, {1'b0, 1'b1, 32'h0, 25'h0});
        reset_n = 1'b1; read_n = 1'b1; avm_readdatavalid = 1'b1; avm_readdata = 32'hFEEDFACE;
        tick; avm_readdatavalid = 1'b0;
        check("rst_late_rdv", {data_ready_n, read_data}, {1'b1, 32'h0});
        read_address = 25'h200; read_n = 1'b0;
        tick; check("post_reset_accept", {avm_read, avm_address}, {1'b1, 25'h200});

        // eight back-to-back writes with varying stalls
        do_reset;
        mon_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            write_address = 25'(4 * i); write_data = 32'hA5A50000 | 32'(i); write_n = 1'b0;
            n = 0;
            while (data_written_n && n < 20) begin
                avm_waitrequest = (n >= 1 && n <= i % 3);
                tick;
                n++;
            end
            check($sformatf("b2b_done%0d", i), data_written_n, 1'b0);
            write_n = 1'b1; avm_waitrequest = 1'b0;
            tick; check($sformatf("b2b_release%0d", i), data_written_n, 1'b1);
        end
        mon_en = 1'b0;
        check("b2b_count", acc_addr.size(), 8);
        foreach (acc_addr[i]) begin
            check($sformatf("b2b_addr%0d", i), acc_addr[i], 25'(4 * i));
            check($sformatf("b2b_data%0d", i), acc_data[i], 32'hA5A50000 | 32'(i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
